sig_ctrl_arb: RTL
=================

SIG_CTRL_ARB -- requirements
Module: sig_ctrl_arb

Interface
REQ-001 Parameter N, default 4, number of signal requesters (2..8).
REQ-002 Parameter PULSE_LEN, default 4, cycles sig_ctrl is held high per grant (>=1).
REQ-003 Parameter GAP_LEN, default 2, low cycles enforced after each pulse (>=1).
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 sig_in  input  N  asynchronous request signals, one per requester, rising edge = request.
REQ-007 sig_ctrl  output  1  shared control pulse, registered.
REQ-008 grant_id  output  clog2(N)  index of requester owning current/last pulse, registered.
REQ-009 busy  output  1  high whenever FSM is not IDLE.
REQ-010 pend  output  N  pending-request flags, registered.
REQ-011 drop_cnt  output  8  count of lost requests, saturating.

Function
REQ-012 Each sig_in bit SHALL pass through a 2-flop synchronizer followed by a third history flop; edge event = sync2 & ~hist.
REQ-013 Edge event on bit i SHALL set pend[i] on the same clock edge that registers the edge; sig_in high first sampled at edge k -> pend[i] high after edge k+2.
REQ-014 Edge event on bit i while pend[i] is set and not being cleared that cycle SHALL leave pend[i] set and increment drop_cnt by 1.
REQ-015 drop_cnt SHALL saturate at 255 and never wrap.
REQ-016 Edge event on bit i in the same cycle its pend[i] is cleared by a grant SHALL leave pend[i] set; no drop counted.
REQ-017 FSM states: IDLE, PULSE, GAP; one-hot or binary encoding is implementer's choice.
REQ-018 IDLE: if any pend bit set, select winner by round-robin, load grant_id, clear pend[winner], reset cycle counter, go PULSE; else stay IDLE.
REQ-019 Round-robin SHALL search from (last_grant+1) mod N upward with wrap; last_grant updates on every grant.
REQ-020 PULSE: sig_ctrl high for exactly PULSE_LEN cycles, then go GAP.
REQ-021 GAP: sig_ctrl low for exactly GAP_LEN cycles, then go IDLE; pend bits continue to accumulate in PULSE and GAP.
REQ-022 sig_ctrl SHALL be high only in PULSE; rises on edge k+3 for the REQ-013 request when FSM was IDLE.
REQ-023 grant_id SHALL hold its value from grant until the next grant.
REQ-024 Back-to-back: IDLE with pend set SHALL grant in the first IDLE cycle, so pulse period = PULSE_LEN+GAP_LEN+1 cycles.
REQ-025 Counter width SHALL cover max(PULSE_LEN, GAP_LEN) without overflow.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, sig_ctrl 0, busy 0, pend 0, drop_cnt 0, grant_id 0, counter 0, last_grant N-1, all synchronizer/history flops 0.
REQ-027 Reset mid-PULSE or mid-GAP SHALL abort the pulse with no residual pulse after release.
REQ-028 sig_in held high across reset release SHALL produce exactly one edge event after release.

Verification
REQ-029 Single request: sig_in[0] rises, first sampled at edge k -> sig_ctrl high edges k+3..k+6 (4 cycles), grant_id=0, low 2 cycles, busy high 6 cycles, pend[0] low after k+3.
REQ-030 All four sig_in rise together -> grants 0,1,2,3 in order, each 4-cycle pulse, pulse starts 7 cycles apart, drop_cnt=0.
REQ-031 Round-robin: after grant 2, pend[0] and pend[3] set -> grant 3 then 0.
REQ-032 Drop: sig_in[1] toggles twice while pend[1] is pending (FSM busy with requester 0) -> one pulse for 1 later, drop_cnt=1.
REQ-033 Saturation: 300 dropped edges -> drop_cnt=255.
REQ-034 Reset asserted in 2nd PULSE cycle -> sig_ctrl 0 asynchronously, pend=0, drop_cnt=0, grant_id=0; no pulse until a new edge.

Source files
------------

// File: rtl/sig_ctrl_arb.sv
// Purpose: arbitrate N asynchronous request edges onto one shared control pulse, with round-robin fairness.
// Latency: the pulse rises 3 edges after the request is first sampled (2 sync + 1 history), when the arbiter is idle.
// Backpressure: none; a request is held as a pending flag, and a repeat edge on an already pending flag is counted in drop_cnt.
module sig_ctrl_arb #(
  parameter int N         = 4,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         sig_in,
  output logic                 sig_ctrl,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic [N-1:0]         pend,
  output logic [7:0]           drop_cnt
);

  localparam int GW     = $clog2(N);
  localparam int MAXLEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  // The counter runs 0..LEN-1, so clog2(MAXLEN) bits are enough.
  localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   last_q, last_d;
  logic [N-1:0]    sync1_q, sync1_d;
  logic [N-1:0]    sync2_q, sync2_d;
  logic [N-1:0]    hist_q, hist_d;
  logic [N-1:0]    pend_q, pend_d;
  logic [7:0]      drop_q, drop_d;
  logic            sig_ctrl_q, sig_ctrl_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    edge_evt;
  logic [N-1:0]    clr;
  logic [N-1:0]    drops;
  logic [GW-1:0]   win;
  logic            found;
  logic [8:0]      drop_sum;

  // Two-flop synchronizer plus a history flop; an event is a new high on the synchronized line.
  always_comb begin
    sync1_d  = sig_in;
    sync2_d  = sync1_q;
    hist_d   = sync2_q;
    edge_evt = sync2_q & ~hist_q;
  end

  // Round-robin pick: search upward from the slot after the last grant, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int off = 1; off <= N; off++) begin
      if (!found && pend_q[(int'(last_q) + off) % N]) begin
        found = 1'b1;
        win   = GW'((int'(last_q) + off) % N);
      end
    end
  end

  // Next-state logic: grant in the first idle cycle, then time the pulse and the gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    last_d  = last_q;
    clr     = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = win;
          last_d  = win;
          clr     = {{(N-1){1'b0}}, 1'b1} << win;
          cnt_d   = '0;
          state_d = S_PULSE;
        end
      end
      S_PULSE: begin
        if (cnt_q == CW'(PULSE_LEN - 1)) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_LEN - 1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Pending flags and drop counter; an edge landing on the flag being granted re-arms it without a drop.
  always_comb begin
    drops    = edge_evt & pend_q & ~clr;
    pend_d   = (pend_q & ~clr) | edge_evt;
    drop_sum = {1'b0, drop_q};
    for (int i = 0; i < N; i++) begin
      drop_sum = drop_sum + {8'd0, drops[i]};
    end
    drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Output decode from the next state, so that the registered outputs line up with the state register.
  always_comb begin
    sig_ctrl_d = (state_d == S_PULSE);
    busy_d     = (state_d != S_IDLE);
  end

  // FSM state, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      grant_q    <= '0;
      last_q     <= GW'(N - 1);
      sig_ctrl_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      sig_ctrl_q <= sig_ctrl_d;
      busy_q     <= busy_d;
    end
  end

  // Synchronizer, pending flags and drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      pend_q  <= pend_d;
      drop_q  <= drop_d;
    end
  end

  assign sig_ctrl = sig_ctrl_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign pend     = pend_q;
  assign drop_cnt = drop_q;

endmodule
